// File: rtl/sysbus_mem_responder.sv
// Sysbus memory-side responder: accepts line read/write requests from the core,
// backs them with a 64-bit-wide store and returns reads as eight tagged beats.
module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 4096,
  parameter int READ_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  input  logic                      bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

  localparam int ADDR_W = $clog2(MEM_WORDS);
  localparam int LINE_W = ADDR_W - 3;
  localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [3:0]       TYPE_MEMORY = 4'h1;
  localparam logic [LAT_W-1:0] LAT_ONE     = LAT_W'(1);
  localparam logic [LAT_W-1:0] LAT_INIT    = LAT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WR_DATA,
    RD_WAIT,
    RD_RESP
  } state_t;

  state_t                     state_q, state_d;
  logic [2:0]                 beat_q;
  logic [LAT_W-1:0]           lat_q;
  logic [LINE_W-1:0]          line_q;
  logic [BUS_TAG_WIDTH-1:0]   tag_q;
  logic                       accept;
  logic                       mem_we;
  logic [BUS_DATA_WIDTH-1:0]  mem [MEM_WORDS];

  // NOTE: the state register uses non-blocking assignment so every flop samples
  // pre-edge values; blocking here would race against the datapath process.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default before the case so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        // A reqcyc still high in the ack cycle is the tail of the request just taken.
        if (bus_reqcyc && !bus_reqack) begin
          accept = 1'b1;
          if (bus_reqtag[11:8] != TYPE_MEMORY) state_d = IDLE;
          else if (bus_reqtag[12])             state_d = WR_DATA;
          else                                 state_d = RD_WAIT;
        end
      end
      WR_DATA: begin
        if (bus_reqcyc) begin
          mem_we = 1'b1;
          if (beat_q == 3'd7) state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (lat_q == '0) state_d = RD_RESP;
      end
      RD_RESP: begin
        if (bus_respcyc && bus_respack && beat_q == 3'd7) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_reqack  <= 1'b0;
      bus_respcyc <= 1'b0;
      bus_resp    <= '0;
      bus_resptag <= '0;
      beat_q      <= '0;
      lat_q       <= '0;
      line_q      <= '0;
      tag_q       <= '0;
    end else begin
      bus_reqack <= accept;
      case (state_q)
        IDLE: begin
          if (accept) begin
            tag_q  <= bus_reqtag;
            line_q <= bus_req[ADDR_W+2:6];
            beat_q <= '0;
            lat_q  <= LAT_INIT;
          end
        end
        WR_DATA: begin
          if (bus_reqcyc) beat_q <= beat_q + 3'd1;
        end
        RD_WAIT: begin
          if (lat_q != '0) lat_q <= lat_q - LAT_ONE;
          else             beat_q <= '0;
        end
        RD_RESP: begin
          // First cycle in RD_RESP fetches beat 0; afterwards each ack fetches the next.
          if (!bus_respcyc) begin
            bus_respcyc <= 1'b1;
            bus_resp    <= mem[{line_q, beat_q}];
            bus_resptag <= tag_q;
          end else if (bus_respack) begin
            if (beat_q == 3'd7) begin
              bus_respcyc <= 1'b0;
              bus_resp    <= '0;
              bus_resptag <= '0;
              beat_q      <= '0;
            end else begin
              beat_q   <= beat_q + 3'd1;
              bus_resp <= mem[{line_q, beat_q + 3'd1}];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the backing store has no reset; its contents must survive a reset,
  // and leaving it out of the reset tree lets it map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[{line_q, beat_q}] <= bus_req;
  end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed bench for sysbus_mem_responder: line writes, reads, backpressure,
// write stalls, address wrap, illegal/early requests and mid-read reset.
module tb_sysbus_mem_responder;

  localparam int READ_LATENCY = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        bus_reqcyc = 1'b0;
  logic [63:0] bus_req = '0;
  logic [12:0] bus_reqtag = '0;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic        bus_respack = 1'b0;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;

  int n_checks = 0;
  int n_fail   = 0;

  sysbus_mem_responder #(
    .BUS_DATA_WIDTH(64),
    .BUS_TAG_WIDTH (13),
    .MEM_WORDS     (4096),
    .READ_LATENCY  (READ_LATENCY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus_reqcyc (bus_reqcyc),
    .bus_req    (bus_req),
    .bus_reqtag (bus_reqtag),
    .bus_reqack (bus_reqack),
    .bus_respcyc(bus_respcyc),
    .bus_respack(bus_respack),
    .bus_resp   (bus_resp),
    .bus_resptag(bus_resptag)
  );

  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // All tasks start just after a falling edge and return just after one.
  task automatic write_line(input logic [63:0] addr, input logic [12:0] tag,
                            input logic [63:0] dbase, input int stall_beat,
                            input int stall_cycles);
    bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag;
    @(negedge clk);
    check("wr_ack", bus_reqack, 1);
    for (int i = 0; i < 8; i++) begin
      if (i == stall_beat) begin
        bus_reqcyc = 1'b0;
        repeat (stall_cycles) @(negedge clk);
      end
      bus_reqcyc = 1'b1; bus_req = dbase + 64'(i); bus_reqtag = 13'h1FFF;
      @(negedge clk);
      check("wr_single_ack", bus_reqack, 0);
    end
    bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0;
  endtask

  task automatic start_read(input logic [63:0] addr, input logic [12:0] tag, input bit pulse);
    int n;
    bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag;
    @(negedge clk);
    check("rd_ack", bus_reqack, 1);
    check("rd_no_early_resp", bus_respcyc, 0);
    bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0;
    n = 0;
    while (!bus_respcyc && n < 20) begin
      @(negedge clk);
      n++;
      if (pulse && n == 1) begin
        bus_reqcyc = 1'b1; bus_req = 64'h8000; bus_reqtag = 13'h1100;
      end
      if (pulse && n == 2) begin
        check("rd_wait_no_ack", bus_reqack, 0);
        bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0;
      end
    end
    check("rd_latency", 64'(n), 64'(READ_LATENCY + 1));
  endtask

  task automatic collect_beats(input logic [12:0] tag, input logic [63:0] dbase,
                               input int stall_beat, input int stall_cycles,
                               input int stop_beat);
    for (int b = 0; b < 8; b++) begin
      check("beat_valid", bus_respcyc, 1);
      check("beat_data", bus_resp, dbase + 64'(b));
      check("beat_tag", 64'(bus_resptag), 64'(tag));
      if (b == stop_beat) return;
      if (b == stall_beat) begin
        bus_respack = 1'b0;
        repeat (stall_cycles) begin
          @(negedge clk);
          check("hold_valid", bus_respcyc, 1);
          check("hold_data", bus_resp, dbase + 64'(b));
          check("hold_tag", 64'(bus_resptag), 64'(tag));
        end
      end
      bus_respack = 1'b1;
      @(negedge clk);
    end
    bus_respack = 1'b0;
    check("end_valid", bus_respcyc, 0);
    check("end_data", bus_resp, 0);
    check("end_tag", 64'(bus_resptag), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_reqack", bus_reqack, 0);
    check("rst_respcyc", bus_respcyc, 0);
    check("rst_resp", bus_resp, 0);
    check("rst_resptag", 64'(bus_resptag), 0);
    reset = 1'b1;
    @(negedge clk);

    // Write then read back-to-back.
    write_line(64'h1000, 13'h1100, 64'hA5A5_0000_0000_00A0, 8, 0);
    start_read(64'h1000, 13'h0105, 1'b0);
    collect_beats(13'h0105, 64'hA5A5_0000_0000_00A0, 8, 0, 8);

    // Backpressure on beat 2.
    start_read(64'h1000, 13'h0107, 1'b0);
    collect_beats(13'h0107, 64'hA5A5_0000_0000_00A0, 2, 3, 8);

    // Write with a 2-cycle stall before beat 5.
    write_line(64'h2000, 13'h11AB, 64'h0123_4567_0000_00B0, 5, 2);
    start_read(64'h2000, 13'h01AB, 1'b0);
    collect_beats(13'h01AB, 64'h0123_4567_0000_00B0, 8, 0, 8);

    // Wrap modulo the store depth, and offset bits ignored.
    write_line(64'h8000, 13'h1100, 64'hCCCC_0000_0000_00C0, 8, 0);
    start_read(64'h0000, 13'h0101, 1'b0);
    collect_beats(13'h0101, 64'hCCCC_0000_0000_00C0, 8, 0, 8);
    start_read(64'h8025, 13'h0102, 1'b0);
    collect_beats(13'h0102, 64'hCCCC_0000_0000_00C0, 8, 0, 8);

    // Non-memory request: acked once, no response, store untouched.
    bus_reqcyc = 1'b1; bus_req = 64'h1000; bus_reqtag = 13'h1203;
    @(negedge clk);
    check("illegal_ack", bus_reqack, 1);
    bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0;
    repeat (8) begin
      @(negedge clk);
      check("illegal_no_ack", bus_reqack, 0);
      check("illegal_no_resp", bus_respcyc, 0);
    end

    // Request pulse during RD_WAIT is ignored; the in-flight read completes.
    start_read(64'h1000, 13'h0104, 1'b1);
    collect_beats(13'h0104, 64'hA5A5_0000_0000_00A0, 8, 0, 8);
    start_read(64'h8000, 13'h0106, 1'b0);
    collect_beats(13'h0106, 64'hCCCC_0000_0000_00C0, 8, 0, 8);

    // Reset in the middle of a read at beat 3.
    write_line(64'h0040, 13'h1100, 64'hDDDD_0000_0000_00D0, 8, 0);
    start_read(64'h0040, 13'h0110, 1'b0);
    collect_beats(13'h0110, 64'hDDDD_0000_0000_00D0, 8, 0, 3);
    #2 reset = 1'b0;
    #1;
    check("midrst_reqack", bus_reqack, 0);
    check("midrst_respcyc", bus_respcyc, 0);
    check("midrst_resp", bus_resp, 0);
    check("midrst_resptag", 64'(bus_resptag), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start_read(64'h0040, 13'h0111, 1'b0);
    collect_beats(13'h0111, 64'hDDDD_0000_0000_00D0, 8, 0, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
